// File: rtl/multicycle_controller.sv
// multicycle_controller: five-stage multicycle RV32 subset controller (R/I/LOAD/STORE) with illegal-opcode trap
module multicycle_controller #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [2:0]          alu_op,
    output logic [2:0]          state,
    output logic                retire,
    output logic [RETIRE_W-1:0] retired_cnt,
    output logic                trap
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
    localparam logic [1:0] C_R = 2'd0, C_I = 2'd1, C_LD = 2'd2, C_ST = 2'd3;
    logic [2:0]          r_state, w_next;
    logic [1:0]          r_cls, w_cls;
    logic                w_legal;
    logic [RETIRE_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
            r_cls   <= C_R;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE && w_legal) r_cls <= w_cls;
            if (retire) r_cnt <= r_cnt + RETIRE_W'(1);
        end
    end
    always_comb begin
        w_legal = 1'b1;
        w_cls   = r_cls;
        case (opcode)
            7'b0110011: w_cls = C_R;
            7'b0010011: w_cls = C_I;
            7'b0000011: w_cls = C_LD;
            7'b0100011: w_cls = C_ST;
            default:    w_legal = 1'b0;
        endcase
    end
    // class bit 1 marks the memory-accessing classes (LOAD/STORE)
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = imem_ready ? DECODE : FETCH;
            DECODE:  w_next = w_legal ? EXECUTE : TRAP;
            EXECUTE: w_next = r_cls[1] ? MEM : WB;
            MEM:     w_next = !dmem_ready ? MEM : (r_cls == C_LD ? WB : FETCH);
            WB:      w_next = FETCH;
            TRAP:    w_next = TRAP;
            default: w_next = FETCH;
        endcase
    end
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        retire     = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            EXECUTE: alu_src = r_cls != C_R;
            MEM: begin
                dmem_read  = r_cls == C_LD;
                dmem_write = r_cls == C_ST;
                alu_src    = 1'b1;
                retire     = r_cls == C_ST && dmem_ready;
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = r_cls == C_LD;
                retire     = 1'b1;
            end
            default: ;
        endcase
        // strobes must fall while reset is held, even before the state register settles
        if (rst) {imem_req, ir_write, pc_write, dmem_read, dmem_write, reg_write, retire} = '0;
    end
    assign state       = r_state;
    assign retired_cnt = r_cnt;
    assign trap        = r_state == TRAP;
endmodule
